cv_ctrl_hub: RTL and testbench



---
 rtl/cv_ctrl_hub.sv | 184 ++++++++++++++++++
 tb/tb_cv_ctrl_hub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_ctrl_hub.sv
// ColecoVision controller front-end: keypad/joystick encoding, turbo fire and
// optional spinner quadrature generation (enabled by defining CV_SPINNER_EN).
module cv_ctrl_hub #(
  parameter int NUM_PORTS = 2,
  parameter int TURBO_DIV = 89478,
  parameter int QUAD_DIV  = 1024,
  parameter int ACC_W     = 10
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [32*NUM_PORTS-1:0] joy_i,
  input  logic [NUM_PORTS-1:0]   turbo_en_i,
  input  logic [8*NUM_PORTS-1:0] spin_i,
  input  logic [NUM_PORTS-1:0]   spin_stb_i,
  input  logic [NUM_PORTS-1:0]   sel_kp_n_i,
  input  logic [NUM_PORTS-1:0]   sel_joy_n_i,
  output logic [4*NUM_PORTS-1:0] ctrl_d_o,
  output logic [NUM_PORTS-1:0]   ctrl_fire_o,
  output logic [NUM_PORTS-1:0]   spin_a_o,
  output logic [NUM_PORTS-1:0]   spin_b_o
);
  localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TURBO_DIV - 1);

  logic [4*NUM_PORTS-1:0] ctrl_d_q, ctrl_d_d;
  logic [NUM_PORTS-1:0]   ctrl_fire_q, ctrl_fire_d;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    logic [19:0]   j;
    logic          unused_hi;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tph_q, tph_d;
    logic          gate, f1_eff, blue_eff;
    logic [3:0]    kp, jd;

    assign j         = joy_i[32*n +: 20];
    assign unused_hi = ^joy_i[32*n+20 +: 12];

    always_comb begin
      tcnt_d = tcnt_q;
      tph_d  = tph_q;
      if (!turbo_en_i[n]) begin
        tcnt_d = '0;
        tph_d  = 1'b1;
      end else if (ce) begin
        if (tcnt_q == T_LAST) begin
          tcnt_d = '0;
          tph_d  = ~tph_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        tcnt_q <= '0;
        tph_q  <= 1'b1;
      end else begin
        tcnt_q <= tcnt_d;
        tph_q  <= tph_d;
      end
    end

    assign gate     = tph_q | ~turbo_en_i[n];
    assign f1_eff   = j[4] & gate;
    assign blue_eff = j[19] & gate;

    // Keypad priority: digits 0..9, then *, #, purple, blue.
    always_comb begin
      kp = 4'b1111;
      if      (j[8])  kp = 4'b0011;
      else if (j[9])  kp = 4'b1110;
      else if (j[10]) kp = 4'b1101;
      else if (j[11]) kp = 4'b0110;
      else if (j[12]) kp = 4'b0001;
      else if (j[13]) kp = 4'b1001;
      else if (j[14]) kp = 4'b0111;
      else if (j[15]) kp = 4'b1100;
      else if (j[16]) kp = 4'b1000;
      else if (j[17]) kp = 4'b1011;
      else if (j[6])  kp = 4'b1010;
      else if (j[7])  kp = 4'b0101;
      else if (j[18]) kp = 4'b0100;
      else if (j[19]) kp = 4'b0010;
    end

    assign jd = ~{j[3], j[0], j[2], j[1]};

    assign ctrl_d_d[4*n +: 4] = (sel_kp_n_i[n] ? 4'b1111 : kp) &
                                (sel_joy_n_i[n] ? 4'b1111 : jd);
    assign ctrl_fire_d[n]     = (sel_kp_n_i[n] | ~blue_eff) &
                                (sel_joy_n_i[n] | ~f1_eff);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ctrl_d_q    <= '1;
      ctrl_fire_q <= '1;
    end else begin
      ctrl_d_q    <= ctrl_d_d;
      ctrl_fire_q <= ctrl_fire_d;
    end
  end

  assign ctrl_d_o    = ctrl_d_q;
  assign ctrl_fire_o = ctrl_fire_q;

`ifdef CV_SPINNER_EN
  localparam int QW = (QUAD_DIV > 1) ? $clog2(QUAD_DIV) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUAD_DIV - 1);
  localparam logic signed [ACC_W+1:0] SMAX = (ACC_W+2)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W+1:0] SMIN = (ACC_W+2)'(-(2**(ACC_W-1)));

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_spin
    logic [QW-1:0]             qcnt_q, qcnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      a_q, a_d, b_q, b_d;
    logic                      fwd, rev;
    logic signed [1:0]         dir;
    logic signed [7:0]         dlt;
    logic signed [ACC_W+1:0]   sum;

    always_comb begin
      qcnt_d = qcnt_q;
      fwd    = 1'b0;
      rev    = 1'b0;
      if (ce) begin
        if (qcnt_q == Q_LAST) begin
          qcnt_d = '0;
          fwd    = (acc_q > 0);
          rev    = (acc_q < 0);
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
    end

    // Strobe delta and step retirement are folded into one saturating update.
    assign dir = fwd ? 2'sd1 : (rev ? -2'sd1 : 2'sd0);
    assign dlt = spin_stb_i[n] ? $signed(spin_i[8*n +: 8]) : 8'sd0;
    assign sum = (ACC_W+2)'(acc_q) + (ACC_W+2)'(dlt) - (ACC_W+2)'(dir);

    always_comb begin
      acc_d = sum[ACC_W-1:0];
      if (sum > SMAX) acc_d = SMAX[ACC_W-1:0];
      if (sum < SMIN) acc_d = SMIN[ACC_W-1:0];
      a_d = a_q;
      b_d = b_q;
      if (fwd) begin
        a_d = ~b_q;
        b_d = a_q;
      end else if (rev) begin
        a_d = b_q;
        b_d = ~a_q;
      end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        qcnt_q <= '0;
        acc_q  <= '0;
        a_q    <= 1'b1;
        b_q    <= 1'b1;
      end else begin
        qcnt_q <= qcnt_d;
        acc_q  <= acc_d;
        a_q    <= a_d;
        b_q    <= b_d;
      end
    end

    assign spin_a_o[n] = a_q;
    assign spin_b_o[n] = b_q;
  end
`else
  logic unused_spin;
  assign unused_spin = ^{spin_i, spin_stb_i};
  assign spin_a_o    = '1;
  assign spin_b_o    = '1;
`endif

endmodule

// File: tb/tb_cv_ctrl_hub.sv
// Bench for cv_ctrl_hub: directed scenarios plus randomized run against a
// behavioural reference model. Spinner scenarios follow CV_SPINNER_EN.
module tb_cv_ctrl_hub;
  localparam int NP   = 2;
  localparam int TD   = 4;
  localparam int QD   = 4;
  localparam int AW   = 10;
  localparam int AMAX = 2**(AW-1) - 1;
  localparam int AMIN = -(2**(AW-1));

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            ce;
  logic [32*NP-1:0] joy;
  logic [NP-1:0]   turbo_en, spin_stb, sel_kp_n, sel_joy_n;
  logic [8*NP-1:0] spin;
  logic [4*NP-1:0] ctrl_d_o;
  logic [NP-1:0]   ctrl_fire_o, spin_a_o, spin_b_o;

  cv_ctrl_hub #(.NUM_PORTS(NP), .TURBO_DIV(TD), .QUAD_DIV(QD), .ACC_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .joy_i(joy),
    .turbo_en_i(turbo_en), .spin_i(spin), .spin_stb_i(spin_stb),
    .sel_kp_n_i(sel_kp_n), .sel_joy_n_i(sel_joy_n),
    .ctrl_d_o(ctrl_d_o), .ctrl_fire_o(ctrl_fire_o),
    .spin_a_o(spin_a_o), .spin_b_o(spin_b_o));

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [3:0] kp_tab [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001,
                              4'b1001, 4'b0111, 4'b1100, 4'b1000, 4'b1011,
                              4'b1010, 4'b0101, 4'b0100, 4'b0010};
  int         kp_bit [14] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 6, 7, 18, 19};
  logic [1:0] qtab [4]    = '{2'b11, 2'b01, 2'b00, 2'b10};

  function automatic logic [3:0] kp_code(input logic [31:0] j);
    for (int i = 0; i < 14; i++)
      if (j[kp_bit[i]]) return kp_tab[i];
    return 4'b1111;
  endfunction

  int   m_tcnt [NP];
  bit   m_tph  [NP];
  int   m_qcnt [NP];
  int   m_acc  [NP];
  int   m_qpos [NP];
  logic [3:0] e_d [NP];
  logic e_f [NP];
  logic e_a [NP];
  logic e_b [NP];

  always @(posedge clk_sys) begin
    for (int n = 0; n < NP; n++) begin
      if (reset) begin
        m_tcnt[n] = 0; m_tph[n] = 1; m_qcnt[n] = 0; m_acc[n] = 0; m_qpos[n] = 0;
        e_d[n] = 4'hF; e_f[n] = 1; e_a[n] = 1; e_b[n] = 1;
      end else begin
        logic [31:0] j;
        logic        pass, f1, bl;
        logic [3:0]  kp, jd;
        int          dir;
        j    = joy[32*n +: 32];
        pass = m_tph[n] || !turbo_en[n];
        f1   = j[4] && pass;
        bl   = j[19] && pass;
        kp   = sel_kp_n[n]  ? 4'hF : kp_code(j);
        jd   = sel_joy_n[n] ? 4'hF : ~{j[3], j[0], j[2], j[1]};
        e_d[n] = kp & jd;
        e_f[n] = (sel_kp_n[n] || !bl) && (sel_joy_n[n] || !f1);
        if (!turbo_en[n]) begin
          m_tcnt[n] = 0; m_tph[n] = 1;
        end else if (ce) begin
          m_tcnt[n]++;
          if (m_tcnt[n] == TD) begin m_tcnt[n] = 0; m_tph[n] = !m_tph[n]; end
        end
`ifdef CV_SPINNER_EN
        dir = 0;
        if (ce) begin
          m_qcnt[n]++;
          if (m_qcnt[n] == QD) begin
            m_qcnt[n] = 0;
            dir = (m_acc[n] > 0) ? 1 : ((m_acc[n] < 0) ? -1 : 0);
          end
        end
        if (spin_stb[n]) m_acc[n] += int'($signed(spin[8*n +: 8]));
        m_acc[n] -= dir;
        if (m_acc[n] > AMAX) m_acc[n] = AMAX;
        if (m_acc[n] < AMIN) m_acc[n] = AMIN;
        m_qpos[n] = (m_qpos[n] + dir + 4) % 4;
        {e_a[n], e_b[n]} = qtab[m_qpos[n]];
`else
        dir = 0;
        e_a[n] = 1; e_b[n] = 1;
`endif
      end
    end
  end

  task automatic idle();
    joy = '0; sel_kp_n = '1; sel_joy_n = '1; turbo_en = '0;
    spin = '0; spin_stb = '0; ce = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    for (int n = 0; n < NP; n++) begin
      chk({tag, "_d"},    32'(ctrl_d_o[4*n +: 4]), 32'(e_d[n]));
      chk({tag, "_fire"}, 32'(ctrl_fire_o[n]),     32'(e_f[n]));
      chk({tag, "_a"},    32'(spin_a_o[n]),        32'(e_a[n]));
      chk({tag, "_b"},    32'(spin_b_o[n]),        32'(e_b[n]));
    end
  endtask

  int        tq[$];
  logic [1:0] abq[$];
  logic [1:0] prev_ab, cur_ab;
  logic      prev_f;
  int        nsteps;

  initial begin
    reset = 1'b1;
    idle();
    do_reset();

    // Reset state
    @(negedge clk_sys);
    chk("rst_d",    32'(ctrl_d_o),    32'hFF);
    chk("rst_fire", 32'(ctrl_fire_o), 32'h3);
    chk("rst_a",    32'(spin_a_o),    32'h3);
    chk("rst_b",    32'(spin_b_o),    32'h3);

    // Keypad priority and one-cycle latency
    sel_kp_n[0] = 1'b0; joy[8] = 1'b1; joy[13] = 1'b1;
    #1 chk("kp_not_early", 32'(ctrl_d_o[3:0]), 32'hF);
    @(negedge clk_sys);
    chk("kp_key0", 32'(ctrl_d_o[3:0]), 32'b0011);
    chk("kp_fire", 32'(ctrl_fire_o[0]), 32'h1);
    joy[8] = 1'b0;
    @(negedge clk_sys);
    chk("kp_key5", 32'(ctrl_d_o[3:0]), 32'b1001);

    // Joystick on port 1, port 0 idle
    idle();
    sel_joy_n[1] = 1'b0; joy[35] = 1'b1; joy[32] = 1'b1; joy[36] = 1'b1;
    @(negedge clk_sys);
    chk("joy1_d",    32'(ctrl_d_o[7:4]),  32'b0011);
    chk("joy1_fire", 32'(ctrl_fire_o[1]), 32'h0);
    chk("p0_d",      32'(ctrl_d_o[3:0]),  32'hF);
    chk("p0_fire",   32'(ctrl_fire_o[0]), 32'h1);

    // Turbo: ce every 4 clocks, TD=4 -> toggle every 16 clocks
    do_reset();
    sel_joy_n[0] = 1'b0; joy[4] = 1'b1; turbo_en[0] = 1'b1;
    tq.delete();
    prev_f = 1'b0;
    for (int k = 0; k < 100; k++) begin
      ce = (k % 4 == 0);
      @(negedge clk_sys);
      if (ctrl_fire_o[0] !== prev_f) tq.push_back(k);
      prev_f = ctrl_fire_o[0];
    end
    chk("turbo_ntog", 32'(tq.size() >= 4), 32'h1);
    for (int i = 1; i < 4 && i < tq.size(); i++)
      chk("turbo_period", 32'(tq[i] - tq[i-1]), 32'd16);
    for (int k = 0; k < 40 && ctrl_fire_o[0] !== 1'b1; k++) begin
      ce = (k % 4 == 0);
      @(negedge clk_sys);
    end
    chk("turbo_off_seen", 32'(ctrl_fire_o[0]), 32'h1);
    turbo_en[0] = 1'b0; ce = 1'b0;
    @(negedge clk_sys);
    chk("turbo_off_fire", 32'(ctrl_fire_o[0]), 32'h0);

`ifdef CV_SPINNER_EN
    // Forward +3
    do_reset();
    spin[7:0] = 8'd3; spin_stb[0] = 1'b1;
    @(negedge clk_sys);
    spin_stb = '0; ce = 1'b1;
    tq.delete(); abq.delete(); prev_ab = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      cur_ab = {spin_a_o[0], spin_b_o[0]};
      if (cur_ab !== prev_ab) begin tq.push_back(k); abq.push_back(cur_ab); end
      prev_ab = cur_ab;
    end
    chk("fwd_nsteps", 32'(abq.size()), 32'd3);
    if (abq.size() == 3) begin
      chk("fwd_ab0", 32'(abq[0]), 32'b01);
      chk("fwd_ab1", 32'(abq[1]), 32'b00);
      chk("fwd_ab2", 32'(abq[2]), 32'b10);
      chk("fwd_gap1", 32'(tq[1] - tq[0]), 32'd4);
      chk("fwd_gap2", 32'(tq[2] - tq[1]), 32'd4);
    end
    chk("fwd_p1_a", 32'(spin_a_o[1]), 32'h1);
    chk("fwd_p1_b", 32'(spin_b_o[1]), 32'h1);

    // Saturation then strobe coincident with a forward step
    do_reset();
    spin[7:0] = 8'd127; spin_stb[0] = 1'b1;
    repeat (5) @(negedge clk_sys);
    spin_stb = '0; ce = 1'b1;
    repeat (3) @(negedge clk_sys);
    spin[7:0] = 8'h80; spin_stb[0] = 1'b1;
    @(negedge clk_sys);
    spin_stb = '0;
    nsteps = 1; prev_ab = {spin_a_o[0], spin_b_o[0]};
    chk("sat_first", 32'(prev_ab), 32'b01);
    for (int k = 0; k < 382*4 + 40; k++) begin
      @(negedge clk_sys);
      cur_ab = {spin_a_o[0], spin_b_o[0]};
      if (cur_ab !== prev_ab) nsteps++;
      prev_ab = cur_ab;
    end
    chk("sat_steps", 32'(nsteps), 32'd383);
    chk("sat_final", 32'(prev_ab), 32'b10);

    // Reverse -2
    do_reset();
    spin[7:0] = 8'hFE; spin_stb[0] = 1'b1;
    @(negedge clk_sys);
    spin_stb = '0; ce = 1'b1;
    tq.delete(); abq.delete(); prev_ab = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      cur_ab = {spin_a_o[0], spin_b_o[0]};
      if (cur_ab !== prev_ab) begin tq.push_back(k); abq.push_back(cur_ab); end
      prev_ab = cur_ab;
    end
    chk("rev_nsteps", 32'(abq.size()), 32'd2);
    if (abq.size() == 2) begin
      chk("rev_ab0", 32'(abq[0]), 32'b10);
      chk("rev_ab1", 32'(abq[1]), 32'b00);
      chk("rev_gap", 32'(tq[1] - tq[0]), 32'd4);
    end
`endif

    // Randomized run against the model, with a mid-run reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < NP; n++)
        joy[32*n +: 32] = ($urandom_range(3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      sel_kp_n  = NP'($urandom);
      sel_joy_n = NP'($urandom);
      if ($urandom_range(7) == 0) turbo_en ^= NP'($urandom_range(3));
      ce       = 1'($urandom);
      spin_stb = ($urandom_range(3) == 0) ? NP'($urandom) : '0;
      spin     = (8*NP)'($urandom);
      if (i == 400) begin
        reset = 1'b1;
        #1;
        chk("mid_rst_d",    32'(ctrl_d_o),    32'hFF);
        chk("mid_rst_fire", 32'(ctrl_fire_o), 32'h3);
        chk("mid_rst_ab",   32'({spin_a_o, spin_b_o}), 32'hF);
        @(negedge clk_sys);
        reset = 1'b0;
      end
      @(negedge clk_sys);
      cmp_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
